// File: rtl/exe_pkg.sv
// Shared encodings and bus geometry for the execute stage.
package exe_pkg;

  typedef enum logic [2:0] {
    DivNone = 3'd0,
    DivDiv  = 3'd1,
    DivDivu = 3'd2,
    DivMod  = 3'd3,
    DivModu = 3'd4
  } div_op_e;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  localparam int unsigned ALU_OP_W   = 12;
  localparam int unsigned DIV_OP_W   = 3;
  localparam int unsigned MEM_SIZE_W = 2;
  localparam int unsigned RF_ADDR_W  = 5;

  // Control header widths sitting above the XLEN-wide fields.
  localparam int unsigned DS2ES_CTRL_W = ALU_OP_W + DIV_OP_W + MEM_SIZE_W + 4 + RF_ADDR_W;
  localparam int unsigned ES2MS_CTRL_W = 1 + MEM_SIZE_W + 1 + 2 + 1 + 1 + RF_ADDR_W;

  function automatic int unsigned ds2es_w(int unsigned xlen);
    return DS2ES_CTRL_W + 4 * xlen;
  endfunction

  function automatic int unsigned es2ms_w(int unsigned xlen);
    return ES2MS_CTRL_W + 2 * xlen;
  endfunction

  function automatic int unsigned es_fwd_w(int unsigned xlen);
    return xlen + 2 + RF_ADDR_W;
  endfunction

  // Field offsets (LSB positions).
  function automatic int unsigned ds2es_ctrl_lsb(int unsigned xlen);
    return 4 * xlen;
  endfunction

  function automatic int unsigned es2ms_result_lsb(int unsigned xlen);
    return xlen;
  endfunction

  function automatic int unsigned es2ms_ctrl_lsb(int unsigned xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/exe_stage_v2_if.sv
// Decode/execute/memory handshake, forwarding and data SRAM request bundle.
interface exe_stage_v2_if #(
  parameter int unsigned XLEN = 32
);
  import exe_pkg::*;

  localparam int unsigned DS2ES_W = ds2es_w(XLEN);
  localparam int unsigned ES2MS_W = es2ms_w(XLEN);
  localparam int unsigned FWD_W   = es_fwd_w(XLEN);

  logic               ds2es_valid;
  logic [DS2ES_W-1:0] ds2es_bus;
  logic               es_allowin;
  logic               flush;
  logic               ms_allowin;
  logic               es2ms_valid;
  logic [ES2MS_W-1:0] es2ms_bus;
  logic [FWD_W-1:0]   es_fwd;
  logic               data_sram_en;
  logic [XLEN/8-1:0]  data_sram_we;
  logic [XLEN-1:0]    data_sram_addr;
  logic [XLEN-1:0]    data_sram_wdata;

  modport master (
    output ds2es_valid, ds2es_bus, flush, ms_allowin,
    input  es_allowin, es2ms_valid, es2ms_bus, es_fwd,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ds2es_valid, ds2es_bus, flush, ms_allowin,
    output es_allowin, es2ms_valid, es2ms_bus, es_fwd,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/alu.sv
// Single-cycle ALU with one-hot operation select.
module alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic [11:0]     alu_op,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic [XLEN-1:0] alu_result
);

  localparam int unsigned SW = $clog2(XLEN);

  logic [XLEN-1:0] add_res, sub_res, slt_res, sltu_res, sra_res;
  logic [SW-1:0]   shamt;

  always_comb begin
    shamt    = alu_src2[SW-1:0];
    add_res  = alu_src1 + alu_src2;
    sub_res  = alu_src1 - alu_src2;
    slt_res  = {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
    sltu_res = {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
    sra_res  = $unsigned($signed(alu_src1) >>> shamt);
    alu_result = ({XLEN{alu_op[0]}}  & add_res)
               | ({XLEN{alu_op[1]}}  & sub_res)
               | ({XLEN{alu_op[2]}}  & slt_res)
               | ({XLEN{alu_op[3]}}  & sltu_res)
               | ({XLEN{alu_op[4]}}  & (alu_src1 & alu_src2))
               | ({XLEN{alu_op[5]}}  & ~(alu_src1 | alu_src2))
               | ({XLEN{alu_op[6]}}  & (alu_src1 | alu_src2))
               | ({XLEN{alu_op[7]}}  & (alu_src1 ^ alu_src2))
               | ({XLEN{alu_op[8]}}  & (alu_src1 << shamt))
               | ({XLEN{alu_op[9]}}  & (alu_src1 >> shamt))
               | ({XLEN{alu_op[10]}} & sra_res)
               | ({XLEN{alu_op[11]}} & alu_src2);
  end

endmodule

// File: rtl/exe_stage_v2_div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, sign fix-up at the output.
module div_iter import exe_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic            abort,
  input  logic            ack,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dsr_q, dvd_q;
  logic            qneg_q, rneg_q, dvz_q;

  logic            go;
  logic [XLEN-1:0] abs_a, abs_b, rem_in, quo_in, dsr_in, rem_nx, quo_nx;
  logic [XLEN:0]   r_sh, diff;

  assign go = start & ~abort & (state_q == DivIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DivIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: if (go) state_d = DivBusy;
      DivBusy: begin
        if (abort)                       state_d = DivIdle;
        else if (cnt_q == CW'(XLEN - 1)) state_d = DivDone;
      end
      DivDone: if (abort | ack) state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
  end

  always_comb begin
    done = (state_q == DivDone);
  end

  // The first iteration runs on the start edge straight from the operands.
  always_comb begin
    abs_a  = (signed_op & dividend[XLEN-1]) ? -dividend : dividend;
    abs_b  = (signed_op & divisor[XLEN-1])  ? -divisor  : divisor;
    rem_in = (state_q == DivIdle) ? '0    : rem_q;
    quo_in = (state_q == DivIdle) ? abs_a : quo_q;
    dsr_in = (state_q == DivIdle) ? abs_b : dsr_q;
    r_sh   = {rem_in, quo_in[XLEN-1]};
    diff   = r_sh - {1'b0, dsr_in};
    rem_nx = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx = {quo_in[XLEN-2:0], ~diff[XLEN]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      dvd_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dvz_q  <= 1'b0;
    end else if (go) begin
      cnt_q  <= CW'(1);
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      dsr_q  <= abs_b;
      dvd_q  <= dividend;
      qneg_q <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      rneg_q <= signed_op & dividend[XLEN-1];
      dvz_q  <= (divisor == '0);
    end else if (state_q == DivBusy) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  always_comb begin
    quotient  = dvz_q ? '1    : (qneg_q ? -quo_q : quo_q);
    remainder = dvz_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
  end

endmodule

// File: rtl/exe_stage_v2.sv
// Execute stage: ALU, iterative divide with handshake stall, data SRAM request, forwarding bus.
module exe_stage_v2 import exe_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DIV_EN = 1
) (
  input logic           clk,
  input logic           reset,
  exe_stage_v2_if.slave pipe
);

  localparam int unsigned DS2ES_W = ds2es_w(XLEN);
  localparam int unsigned NB      = XLEN / 8;

  logic               es_valid_q;
  logic [DS2ES_W-1:0] ds_bus_q;

  logic [11:0]     alu_op;
  logic [2:0]      div_op;
  logic [1:0]      mem_size;
  logic            mem_sext, res_from_mem, mem_we, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] src1, src2, rkd_value, pc;

  logic            es_allowin, es_ready_go, es2ms_valid, is_div, div_done, depart;
  logic            div_signed, div_sel_rem, ale, sram_en, fwd_valid, fwd_block;
  logic [XLEN-1:0] alu_result, div_quo, div_rem, result;
  logic [NB-1:0]   byte_mask;
  logic [XLEN-1:0] wdata;

  assign {alu_op, div_op, mem_size, mem_sext, res_from_mem, mem_we, rf_we, rf_waddr,
          src1, src2, rkd_value, pc} = ds_bus_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           es_valid_q <= 1'b0;
    else if (pipe.flush) es_valid_q <= 1'b0;
    else if (es_allowin) es_valid_q <= pipe.ds2es_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ds_bus_q <= '0;
    else if (pipe.ds2es_valid & es_allowin & ~pipe.flush) ds_bus_q <= pipe.ds2es_bus;
  end

  always_comb begin
    is_div      = (div_op != DivNone);
    div_signed  = (div_op == DivDiv) | (div_op == DivMod);
    div_sel_rem = (div_op == DivMod) | (div_op == DivModu);
    es_ready_go = ~is_div | div_done;
    es_allowin  = ~es_valid_q | (es_ready_go & pipe.ms_allowin);
    es2ms_valid = es_valid_q & es_ready_go & ~pipe.flush;
    depart      = es2ms_valid & pipe.ms_allowin;
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .alu_op    (alu_op),
    .alu_src1  (src1),
    .alu_src2  (src2),
    .alu_result(alu_result)
  );

  if (DIV_EN != 0) begin : g_div
    div_iter #(
      .XLEN(XLEN)
    ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (es_valid_q & is_div),
      .signed_op(div_signed),
      .abort    (pipe.flush),
      .ack      (depart),
      .dividend (src1),
      .divisor  (src2),
      .done     (div_done),
      .quotient (div_quo),
      .remainder(div_rem)
    );
  end else begin : g_no_div
    assign div_done = 1'b1;
    assign div_quo  = '0;
    assign div_rem  = '0;
  end

  always_comb begin
    result = is_div ? (div_sel_rem ? div_rem : div_quo) : alu_result;
    ale    = ((mem_size == MemHalf) & alu_result[0])
           | ((mem_size == MemWord) & (alu_result[1:0] != 2'b00));
    sram_en = es_valid_q & (res_from_mem | mem_we) & ~ale & pipe.ms_allowin & ~pipe.flush;
  end

  // Lane replication is done bitwise so narrow XLEN never needs a zero replication count.
  always_comb begin
    case (mem_size)
      MemByte: byte_mask = NB'(1) << alu_result[1:0];
      MemHalf: byte_mask = NB'(3) << alu_result[1:0];
      default: byte_mask = '1;
    endcase
    wdata = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      case (mem_size)
        MemByte: wdata[i] = rkd_value[i % 8];
        MemHalf: wdata[i] = rkd_value[i % 16];
        default: wdata[i] = rkd_value[i];
      endcase
    end
  end

  always_comb begin
    fwd_valid = es_valid_q & rf_we & (rf_waddr != 5'd0);
    fwd_block = fwd_valid & (res_from_mem | (is_div & ~div_done));
  end

  assign pipe.es_allowin      = es_allowin;
  assign pipe.es2ms_valid     = es2ms_valid;
  assign pipe.es2ms_bus       = {res_from_mem, mem_size, mem_sext, alu_result[1:0], ale, rf_we,
                                 rf_waddr, result, pc};
  assign pipe.es_fwd          = {fwd_valid, fwd_block, rf_waddr, result};
  assign pipe.data_sram_en    = sram_en;
  assign pipe.data_sram_we    = (mem_we & sram_en) ? byte_mask : '0;
  assign pipe.data_sram_addr  = alu_result;
  assign pipe.data_sram_wdata = wdata;

endmodule

// File: tb/tb_exe_stage_v2.sv
// Directed bench for exe_stage_v2 at XLEN=32 with hand-computed expectations.
module tb_exe_stage_v2;
  import exe_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DW   = ds2es_w(XLEN);
  localparam logic [11:0] ADD  = 12'h001;
  localparam logic [11:0] NOOP = 12'h000;
  localparam logic [31:0] PC   = 32'h1C00_0040;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  exe_stage_v2_if #(.XLEN(XLEN)) pipe ();

  exe_stage_v2 #(
    .XLEN  (XLEN),
    .DIV_EN(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pipe (pipe)
  );

  always #5 clk = ~clk;

  logic [31:0] res;
  logic        ale, fwd_valid, fwd_block;
  assign res       = pipe.es2ms_bus[2*XLEN-1:XLEN];
  assign ale       = pipe.es2ms_bus[2*XLEN+6];
  assign fwd_valid = pipe.es_fwd[XLEN+6];
  assign fwd_block = pipe.es_fwd[XLEN+5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [11:0] aop, input logic [2:0] dop,
                                       input logic [1:0] msz, input logic rfm, input logic mwe,
                                       input logic rfwe, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [31:0] rkd);
    return {aop, dop, msz, 1'b0, rfm, mwe, rfwe, 5'd4, s1, s2, rkd, PC};
  endfunction

  task automatic drive_one(input logic [DW-1:0] bus);
    pipe.ds2es_valid = 1'b1;
    pipe.ds2es_bus   = bus;
    tick();
    pipe.ds2es_valid = 1'b0;
  endtask

  // Issues one divide and waits (bounded) for completion, checking latency and result.
  task automatic run_div(input string tag, input logic [2:0] dop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic alw;
    drive_one(mk(NOOP, dop, 2'd0, 1'b0, 1'b0, 1'b1, a, b, 32'd0));
    chk({tag, "_block"}, 32'(fwd_block), 32'd1);
    n   = 0;
    alw = 1'b0;
    while (!pipe.es2ms_valid && n < 100) begin
      alw = alw | pipe.es_allowin;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd32);
    chk({tag, "_allowin_low"}, 32'(alw), 32'd0);
    chk({tag, "_result"}, res, exp);
  endtask

  initial begin
    reset            = 1'b1;
    pipe.ds2es_valid = 1'b0;
    pipe.ds2es_bus   = '0;
    pipe.flush       = 1'b0;
    pipe.ms_allowin  = 1'b1;
    #2;
    chk("rst_allowin", 32'(pipe.es_allowin), 32'd1);
    chk("rst_valid", 32'(pipe.es2ms_valid), 32'd0);
    chk("rst_sram_en", 32'(pipe.data_sram_en), 32'd0);
    chk("rst_sram_we", 32'(pipe.data_sram_we), 32'd0);
    chk("rst_fwd", pipe.es_fwd[31:0], 32'd0);
    chk("rst_fwd_hi", 32'(pipe.es_fwd[38:32]), 32'd0);
    chk("rst_result", res, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Three back-to-back ADDs
    pipe.ds2es_valid = 1'b1;
    pipe.ds2es_bus   = mk(ADD, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0);
    tick();
    pipe.ds2es_bus = mk(ADD, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd10, 32'd20, 32'd0);
    chk("add1_valid", 32'(pipe.es2ms_valid), 32'd1);
    chk("add1_result", res, 32'd3);
    chk("add1_allowin", 32'(pipe.es_allowin), 32'd1);
    chk("add1_pc", pipe.es2ms_bus[31:0], PC);
    chk("add1_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("add1_fwd_block", 32'(fwd_block), 32'd0);
    chk("add1_sram_en", 32'(pipe.data_sram_en), 32'd0);
    tick();
    pipe.ds2es_bus = mk(ADD, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("add2_valid", 32'(pipe.es2ms_valid), 32'd1);
    chk("add2_result", res, 32'd30);
    chk("add2_allowin", 32'(pipe.es_allowin), 32'd1);
    tick();
    pipe.ds2es_valid = 1'b0;
    chk("add3_valid", 32'(pipe.es2ms_valid), 32'd1);
    chk("add3_result", res, 32'd0);
    tick();
    chk("add_drained", 32'(pipe.es2ms_valid), 32'd0);
    chk("add_drained_fwd", 32'(fwd_valid), 32'd0);

    // Divides, chained back-to-back
    run_div("div_neg", 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divu_zero", 3'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_div("div_min", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div_mix", 3'd1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_div("modu", 3'd4, 32'd100, 32'd7, 32'd2);
    run_div("mod_zero", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_div("reserved", 3'd7, 32'hFFFF_FFF0, 32'h10, 32'h0FFF_FFFF);
    tick();

    // Memory requests
    drive_one(mk(ADD, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd3, 32'h0000_00A5));
    chk("sb_en", 32'(pipe.data_sram_en), 32'd1);
    chk("sb_we", 32'(pipe.data_sram_we), 32'h8);
    chk("sb_wdata", pipe.data_sram_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", pipe.data_sram_addr, 32'h1003);
    chk("sb_ale", 32'(ale), 32'd0);
    drive_one(mk(ADD, 3'd0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd2, 32'h1234_BEEF));
    chk("sh_we", 32'(pipe.data_sram_we), 32'hC);
    chk("sh_wdata", pipe.data_sram_wdata, 32'hBEEF_BEEF);
    drive_one(mk(ADD, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd4, 32'hDEAD_BEEF));
    chk("sw_we", 32'(pipe.data_sram_we), 32'hF);
    chk("sw_wdata", pipe.data_sram_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", pipe.data_sram_addr, 32'h1004);
    drive_one(mk(ADD, 3'd0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd1, 32'h0000_1234));
    chk("sh_mis_ale", 32'(ale), 32'd1);
    chk("sh_mis_en", 32'(pipe.data_sram_en), 32'd0);
    chk("sh_mis_we", 32'(pipe.data_sram_we), 32'd0);
    drive_one(mk(ADD, 3'd0, 2'd2, 1'b1, 1'b0, 1'b1, 32'h2000, 32'd8, 32'd0));
    chk("lw_en", 32'(pipe.data_sram_en), 32'd1);
    chk("lw_we", 32'(pipe.data_sram_we), 32'd0);
    chk("lw_fwd_block", 32'(fwd_block), 32'd1);
    tick();

    // Store held by ms_allowin low for three cycles
    pipe.ms_allowin = 1'b0;
    drive_one(mk(ADD, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'd1, 32'h0000_005A));
    chk("stall_en_c1", 32'(pipe.data_sram_en), 32'd0);
    chk("stall_allowin", 32'(pipe.es_allowin), 32'd0);
    tick();
    chk("stall_en_c2", 32'(pipe.data_sram_en), 32'd0);
    tick();
    chk("stall_en_c3", 32'(pipe.data_sram_en), 32'd0);
    chk("stall_addr", pipe.data_sram_addr, 32'h3001);
    tick();
    pipe.ms_allowin = 1'b1;
    #1;
    chk("stall_release_en", 32'(pipe.data_sram_en), 32'd1);
    chk("stall_release_we", 32'(pipe.data_sram_we), 32'h2);
    chk("stall_release_wdata", pipe.data_sram_wdata, 32'h5A5A_5A5A);
    tick();
    chk("stall_after_en", 32'(pipe.data_sram_en), 32'd0);

    // Flush in divide cycle 10
    drive_one(mk(NOOP, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1, 32'd1000, 32'd10, 32'd0));
    repeat (10) tick();
    pipe.flush = 1'b1;
    #1;
    chk("flush_valid", 32'(pipe.es2ms_valid), 32'd0);
    tick();
    pipe.flush = 1'b0;
    chk("flush_allowin", 32'(pipe.es_allowin), 32'd1);
    chk("flush_fwd_valid", 32'(fwd_valid), 32'd0);
    drive_one(mk(ADD, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0));
    chk("post_flush_add_valid", 32'(pipe.es2ms_valid), 32'd1);
    chk("post_flush_add_result", res, 32'd11);
    run_div("div_after_flush", 3'd1, 32'd1000, 32'd10, 32'd100);
    tick();

    // Asynchronous reset mid-divide
    drive_one(mk(NOOP, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1, 32'd20, 32'd6, 32'd0));
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("async_rst_allowin", 32'(pipe.es_allowin), 32'd1);
    chk("async_rst_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();
    reset = 1'b0;
    run_div("div_after_rst", 3'd1, 32'd20, 32'd6, 32'd3);
    tick();
    chk("final_drained", 32'(pipe.es2ms_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage_v2.md
# exe_stage_v2

Parametrised execute stage for the in-order five-stage pipeline, sitting between the decode stage (ds) and the memory stage (ms). It evaluates single-cycle ALU operations through the existing `alu`, runs signed and unsigned divide and modulo on an iterative divider, and stalls the valid/allowin handshake while a divide is in flight. It also generates byte-, half- and word-sized data SRAM requests with byte enables and misalignment detection, and publishes a forwarding/hazard bus for decode.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be a power of two, minimum 8.
- `DIV_EN`, 1: when 0, the divider is not built and divide ops produce 0 in one cycle.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ds2es_valid`  in  1  decode holds a valid instruction.
- `ds2es_bus`  in  `DS2ES_W`  packed in MSB-to-LSB order: alu_op[11:0], div_op[2:0], mem_size[1:0], mem_sext, res_from_mem, mem_we, rf_we, rf_waddr[4:0], src1, src2, rkd_value, pc (XLEN each).
- `es_allowin`  out  1  stage can accept a new instruction this cycle.
- `flush`  in  1  kill the resident instruction.
- `ms_allowin`  in  1  memory stage can accept.
- `es2ms_valid`  out  1  resident instruction is complete and valid.
- `es2ms_bus`  out  `ES2MS_W`  packed: res_from_mem, mem_size, mem_sext, addr_lo[1:0], ale, rf_we, rf_waddr, result, pc.
- `es_fwd`  out  `XLEN+7`  packed: fwd_valid, fwd_block, rf_waddr[4:0], result.
- `data_sram_en`  out  1  request strobe.
- `data_sram_we`  out  `XLEN/8`  byte write enables.
- `data_sram_addr`  out  `XLEN`  request address.
- `data_sram_wdata`  out  `XLEN`  request write data.

## Operation
- `es_valid` register: cleared by reset. When `flush` is high, it is cleared on the next edge regardless of other inputs. Otherwise, when `es_allowin` is high, it loads `ds2es_valid`.
- Payload registers load on `ds2es_valid & es_allowin & ~flush`.
- `es_allowin = ~es_valid | (es_ready_go & ms_allowin)`.
- `es2ms_valid = es_valid & es_ready_go & ~flush`.
- `es_ready_go = ~is_div | div_done`, where `is_div = (div_op != 0)`.
- div_op encoding: 1=DIV, 2=DIVU, 3=MOD, 4=MODU; other nonzero values are reserved and treated as DIVU.
- Divide corner cases:
  - Divisor 0: quotient is all-ones, remainder is the dividend.
  - Signed MIN / -1: quotient is MIN, remainder is 0.
- `result`: the divider output when `is_div`, otherwise the ALU output. The memory address is the ALU output.
- Misalignment: `ale` is set for a half access with addr[0]=1, or a word access with addr[1:0]≠0.
- `data_sram_en = es_valid & (res_from_mem | mem_we) & ~ale & ms_allowin & ~flush`. It is asserted for exactly one cycle per memory instruction.
- Write enables: byte access uses 1<<addr[1:0]; half access uses 3<<addr[1:0]; word access uses all ones. Enables are gated by `mem_we` and by `data_sram_en`.
- Write data: byte replicated XLEN/8 times, half replicated XLEN/16 times, word unchanged.
- `es_fwd`:
  - fwd_valid = es_valid & rf_we & (rf_waddr≠0).
  - fwd_block = fwd_valid & (res_from_mem | (is_div & ~div_done)).

## Timing
- Reset values: all outputs are 0, except `es_allowin`=1.
- Non-divide ops have 1-cycle residence; the result is combinational from the registered operands.
- Divide:
  - Cycle 0 is the first cycle with `es_valid` high; the divider starts then.
  - The divider iterates XLEN cycles.
  - `div_done` goes high in cycle XLEN and holds until the instruction leaves.
  - Minimum residence is XLEN+1 cycles.
- Divider FSM:
  - IDLE→BUSY on start.
  - BUSY→DONE when the count reaches XLEN-1.
  - DONE→IDLE on the departure edge (`es2ms_valid & ms_allowin`) or on `flush`.
  - `flush` in BUSY returns the FSM to IDLE next edge and discards the result.
- Back-to-back divides: the second starts in the cycle after the first departs. There is no stale `div_done` carry-over.
- An `ms_allowin` low stall holds all payload and the divider result unchanged, and suppresses `data_sram_en`.
- `reset` asserted mid-divide returns the FSM to IDLE asynchronously and drops `es_valid` immediately.

## Structure
- Shared package `exe_pkg`:
  - div_op and mem_size encodings.
  - Field widths and offsets of `ds2es_bus` and `es2ms_bus`.
  - `DS2ES_W` and `ES2MS_W` as functions of XLEN.
- Sub-module `div_iter`: radix-2 restoring divider with start/busy/done and signed pre/post fix-up; generated only when `DIV_EN`=1.
- The existing `alu` is instantiated unchanged, with width XLEN.

## Test plan
- Three back-to-back ADDs, ms_allowin=1 → `es2ms_valid` high 3 consecutive cycles; results match; `es_allowin` never drops.
- DIV -7 / 2 at XLEN=32 → quotient -3. MOD gives -1. `es2ms_valid` rises exactly 32 cycles after the first valid cycle; `es_allowin`=0 meanwhile.
- DIVU x/0 → result 0xFFFFFFFF. DIV 0x80000000 / -1 → 0x80000000. MOD 0x80000000 / -1 → 0.
- SB 0xA5 to addr 0x1003 → we=4'b1000, wdata=0xA5A5A5A5. SH to addr 0x1001 → ale=1, `data_sram_en`=0.
- Store with ms_allowin low for 3 cycles → `data_sram_en` pulses once, in the cycle ms_allowin returns high.
- `flush` asserted in divide cycle 10 → next cycle `es_valid`=0 and the FSM is IDLE; a following ADD completes in 1 cycle with the correct result.
